// File: rtl/calc_pkg.sv
// calc_pkg: shared types and constants for the binary calculator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package calc_pkg;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  // Controller states, in the order the command flow visits them.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_K1,
    ST_K2,
    ST_K3,
    ST_ACTIVE,
    ST_WRITE,
    ST_READ,
    ST_LOAD,
    ST_TX,
    ST_DONE
  } state_e;

  // ALU opcodes; the numeric value is the Sel field carried in every word.
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_SHL  = 4'd4,
    OP_SHR  = 4'd5,
    OP_AND  = 4'd6,
    OP_OR   = 4'd7,
    OP_XOR  = 4'd8,
    OP_NOT  = 4'd9,
    OP_NAND = 4'd10,
    OP_NOR  = 4'd11,
    OP_XNOR = 4'd12,
    OP_EQ   = 4'd13,
    OP_LT   = 4'd14,
    OP_GT   = 4'd15
  } opcode_e;

  // Packed word is {opcode, A, B, result}.
  function automatic int calc_word_w(input int bits);
    return 4 + 3 * bits;
  endfunction

endpackage

// File: rtl/calc_alu.sv
// calc_alu: 16-operation ALU, every result truncated to Bits.
// Latency: purely combinational.
// Backpressure: none.
module calc_alu
  import calc_pkg::*;
#(
  parameter int Bits = 8
) (
  input  logic [Bits-1:0] i_a,
  input  logic [Bits-1:0] i_b,
  input  logic [3:0]      i_sel,
  output logic [Bits-1:0] o_res
);

  opcode_e w_op;

  assign w_op = opcode_e'(i_sel);

  // Select the operation; comparisons return 1/0 in the low bit, divide by zero returns 0.
  always_comb begin
    o_res = '0;
    case (w_op)
      OP_ADD:  o_res = i_a + i_b;
      OP_SUB:  o_res = i_a - i_b;
      OP_MUL:  o_res = i_a * i_b;
      OP_DIV:  o_res = (i_b == '0) ? '0 : i_a / i_b;
      OP_SHL:  o_res = i_a << i_b;
      OP_SHR:  o_res = i_a >> i_b;
      OP_AND:  o_res = i_a & i_b;
      OP_OR:   o_res = i_a | i_b;
      OP_XOR:  o_res = i_a ^ i_b;
      OP_NOT:  o_res = ~i_a;
      OP_NAND: o_res = ~(i_a & i_b);
      OP_NOR:  o_res = ~(i_a | i_b);
      OP_XNOR: o_res = ~(i_a ^ i_b);
      OP_EQ:   o_res = Bits'(i_a == i_b);
      OP_LT:   o_res = Bits'(i_a < i_b);
      OP_GT:   o_res = Bits'(i_a > i_b);
      default: o_res = '0;
    endcase
  end

endmodule

// File: rtl/binary_calculator_core.sv
// binary_calculator_core: key-unlocked calculator storing {Sel,A,B,Result} words and shifting them out serially.
// Latency: ACTIVE on the 4th key edge, write lands 2 cycles after ACTIVE, first bit on the first ClkTx rise after LOAD.
// Backpressure: none; ValidCmd qualifies commands and a running transmission cannot be stalled or aborted except by Reset.
module binary_calculator_core
  import calc_pkg::*;
#(
  parameter int Bits = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              InputKey,
  input  logic              ValidCmd,
  input  logic              RWMem,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [Bits-1:0]   lnA,
  input  logic [Bits-1:0]   lnB,
  input  logic [3:0]        Sel,
  input  logic              ConfigDiv,
  input  logic [31:0]       Din,
  output logic              CalcActive,
  output logic              CalcMode,
  output logic              Busy,
  output logic              DOutValid,
  output logic              DataOut,
  output logic              ClkTx
);

  localparam int W  = calc_word_w(Bits);
  localparam int FW = W - Bits;            // stored fields without the result
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W);

  state_e r_state;
  state_e w_state_nxt;

  // Divider: the pending value is adopted by the running counter only at a wrap.
  logic [31:0] r_div_pend;
  logic [31:0] r_div_act;
  logic [31:0] r_cnt;
  logic        r_clktx;
  logic        w_wrap;
  logic        w_tx_rise;

  logic [W-1:0]    r_mem [DEPTH];
  logic [FW-1:0]   r_rd_fields;
  logic [W-1:0]    r_shreg;
  logic [CW-1:0]   r_bit_cnt;

  logic r_calc_active;
  logic r_calc_mode;
  logic r_busy;
  logic r_dout_vld;
  logic r_dout;

  logic [Bits-1:0] w_a;
  logic [Bits-1:0] w_b;
  logic [Bits-1:0] w_res;
  logic [3:0]      w_sel;
  logic [W-1:0]    w_word;

  // Operand muxes: live inputs while writing, fetched fields while reading back.
  assign w_sel  = r_calc_mode ? Sel : r_rd_fields[FW-1 -: 4];
  assign w_a    = r_calc_mode ? lnA : r_rd_fields[2*Bits-1 -: Bits];
  assign w_b    = r_calc_mode ? lnB : r_rd_fields[Bits-1:0];
  assign w_word = {w_sel, w_a, w_b, w_res};

  calc_alu #(
    .Bits(Bits)
  ) u_alu (
    .i_a  (w_a),
    .i_b  (w_b),
    .i_sel(w_sel),
    .o_res(w_res)
  );

  // The counter toggles ClkTx every r_div_act cycles; a 0->1 toggle is the bit strobe.
  assign w_wrap    = (r_cnt >= (r_div_act - 32'd1));
  assign w_tx_rise = w_wrap && !r_clktx;

  // Free-running transmit clock divider, reprogrammable at any time.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_div_pend <= 32'd1;
      r_div_act  <= 32'd1;
      r_cnt      <= '0;
      r_clktx    <= 1'b0;
    end else begin
      if (ConfigDiv) begin
        r_div_pend <= (Din == 32'd0) ? 32'd1 : Din;
      end
      if (w_wrap) begin
        r_cnt     <= '0;
        r_clktx   <= ~r_clktx;
        r_div_act <= r_div_pend;
      end else begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: key 1,0,1,0 unlocks; a stray 1 restarts the sequence at K1.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (ValidCmd && InputKey) w_state_nxt = ST_K1;
      end
      ST_K1: begin
        if (!ValidCmd)     w_state_nxt = ST_IDLE;
        else if (InputKey) w_state_nxt = ST_K1;
        else               w_state_nxt = ST_K2;
      end
      ST_K2: begin
        if (ValidCmd && InputKey) w_state_nxt = ST_K3;
        else                      w_state_nxt = ST_IDLE;
      end
      ST_K3: begin
        if (!ValidCmd)     w_state_nxt = ST_IDLE;
        else if (InputKey) w_state_nxt = ST_K1;
        else               w_state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: w_state_nxt = RWMem ? ST_WRITE : ST_READ;
      ST_WRITE:  w_state_nxt = ST_DONE;
      ST_READ:   w_state_nxt = ST_LOAD;
      ST_LOAD:   w_state_nxt = ST_TX;
      ST_TX: begin
        if (w_tx_rise && (r_bit_cnt == LAST)) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (!ValidCmd) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Word memory, cleared on reset and written only from WRITE.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (r_state == ST_WRITE) begin
      r_mem[Addr] <= w_word;
    end
  end

  // Read fetch, shift register load and serializer; each bit is held one full ClkTx period.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_rd_fields <= '0;
      r_shreg     <= '0;
      r_bit_cnt   <= '0;
      r_busy      <= 1'b0;
      r_dout_vld  <= 1'b0;
      r_dout      <= 1'b0;
    end else begin
      case (r_state)
        ST_READ: begin
          r_rd_fields <= r_mem[Addr][W-1:Bits];
          r_busy      <= 1'b1;
        end
        ST_LOAD: begin
          r_shreg   <= w_word;
          r_bit_cnt <= '0;
        end
        ST_TX: begin
          if (w_tx_rise) begin
            if (r_bit_cnt == LAST) begin
              r_dout_vld <= 1'b0;
              r_dout     <= 1'b0;
              r_busy     <= 1'b0;
            end else begin
              r_dout     <= r_shreg[W-1];
              r_shreg    <= {r_shreg[W-2:0], 1'b0};
              r_dout_vld <= 1'b1;
              r_bit_cnt  <= r_bit_cnt + CW'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Status flags: active one cycle after entering ACTIVE, mode latched in ACTIVE and cleared in IDLE.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_calc_active <= 1'b0;
      r_calc_mode   <= 1'b0;
    end else begin
      r_calc_active <= (r_state inside {ST_ACTIVE, ST_WRITE, ST_READ, ST_LOAD, ST_TX, ST_DONE});
      if (r_state == ST_ACTIVE) begin
        r_calc_mode <= RWMem;
      end else if (r_state == ST_IDLE) begin
        r_calc_mode <= 1'b0;
      end
    end
  end

  assign CalcActive = r_calc_active;
  assign CalcMode   = r_calc_mode;
  assign Busy       = r_busy;
  assign DOutValid  = r_dout_vld;
  assign DataOut    = r_dout;
  assign ClkTx      = r_clktx;

endmodule

// File: tb/tb_binary_calculator_core.sv
// tb_binary_calculator_core: scoreboard bench for the key-unlocked calculator.
// Latency: n/a.
// Backpressure: n/a.
module tb_binary_calculator_core;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        InputKey = 1'b0;
  logic        ValidCmd = 1'b0;
  logic        RWMem = 1'b0;
  logic [7:0]  Addr = '0;
  logic [7:0]  lnA = '0;
  logic [7:0]  lnB = '0;
  logic [3:0]  Sel = '0;
  logic        ConfigDiv = 1'b0;
  logic [31:0] Din = '0;
  logic        CalcActive, CalcMode, Busy, DOutValid, DataOut, ClkTx;

  binary_calculator_core dut (
    .Clk(Clk), .Reset(Reset), .InputKey(InputKey), .ValidCmd(ValidCmd),
    .RWMem(RWMem), .Addr(Addr), .lnA(lnA), .lnB(lnB), .Sel(Sel),
    .ConfigDiv(ConfigDiv), .Din(Din), .CalcActive(CalcActive),
    .CalcMode(CalcMode), .Busy(Busy), .DOutValid(DOutValid),
    .DataOut(DataOut), .ClkTx(ClkTx)
  );

  always #5 Clk = ~Clk;

  int          n_checks = 0;
  int          n_pass = 0;
  int          exp_period = 2;
  logic [27:0] exp_q[$];
  logic [27:0] mdl_mem[256];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
  endtask

  // Reference ALU from the opcode table, plain integer arithmetic.
  function automatic logic [7:0] ref_alu(input int sel, input int a, input int b);
    int r;
    case (sel)
      0:  r = a + b;
      1:  r = a - b;
      2:  r = a * b;
      3:  r = (b == 0) ? 0 : a / b;
      4:  r = (b > 7) ? 0 : a * (1 << b);
      5:  r = (b > 7) ? 0 : a / (1 << b);
      6:  r = a & b;
      7:  r = a | b;
      8:  r = a ^ b;
      9:  r = 255 - a;
      10: r = 255 - (a & b);
      11: r = 255 - (a | b);
      12: r = 255 - (a ^ b);
      13: r = (a == b) ? 1 : 0;
      14: r = (a < b) ? 1 : 0;
      15: r = (a > b) ? 1 : 0;
      default: r = 0;
    endcase
    r = r & 255;
    return r[7:0];
  endfunction

  function automatic logic [27:0] ref_word(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b);
    return {sel, a, b, ref_alu(int'(sel), int'(a), int'(b))};
  endfunction

  function automatic logic [27:0] model_read(input logic [7:0] addr);
    logic [27:0] w;
    w = mdl_mem[addr];
    return ref_word(w[27:24], w[23:16], w[15:8]);
  endfunction

  // Monitor: assemble a word from the bits presented on each ClkTx rise, then pop and compare.
  int          mon_nbits = 0;
  int          cyc_since = 0;
  logic [27:0] mon_shw = '0;
  logic        prev_clk = 1'b0;
  bit          per_ok = 1'b1;
  bit          busy_ok = 1'b1;

  always @(negedge Clk) begin
    if (Reset) begin
      mon_nbits = 0;
      cyc_since = 0;
      prev_clk  = 1'b0;
    end else begin
      cyc_since++;
      if (ClkTx && !prev_clk && DOutValid) begin
        if (mon_nbits == 0) begin
          per_ok  = 1'b1;
          busy_ok = 1'b1;
        end else if (cyc_since != exp_period) begin
          per_ok = 1'b0;
        end
        if (!Busy) busy_ok = 1'b0;
        mon_shw = {mon_shw[26:0], DataOut};
        mon_nbits++;
        cyc_since = 0;
        if (mon_nbits == 28) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", 32'(mon_shw), 32'hFFFF_FFFF);
          end else begin
            chk("tx_word", 32'(mon_shw), 32'(exp_q.pop_front()));
            chk("tx_bit_period", 32'(per_ok), 32'd1);
            chk("tx_busy_high", 32'(busy_ok), 32'd1);
          end
          mon_nbits = 0;
        end
      end
      prev_clk = ClkTx;
    end
  end

  // Caller is at a negedge (or time 0); reset is applied at the next posedge.
  task automatic do_reset();
    logic [3:0] pat;
    Reset = 1'b1; ValidCmd = 1'b0; InputKey = 1'b0; ConfigDiv = 1'b0;
    @(negedge Clk);
    chk("rst_calc_active", 32'(CalcActive), 32'd0);
    chk("rst_calc_mode",   32'(CalcMode),   32'd0);
    chk("rst_busy",        32'(Busy),       32'd0);
    chk("rst_dout_valid",  32'(DOutValid),  32'd0);
    chk("rst_data_out",    32'(DataOut),    32'd0);
    chk("rst_clktx",       32'(ClkTx),      32'd0);
    for (int i = 0; i < 256; i++) mdl_mem[i] = '0;
    exp_q.delete();
    exp_period = 2;
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      @(negedge Clk);
      pat[i] = ClkTx;
    end
    chk("rst_clktx_period2", 32'(pat), 32'hA);
  endtask

  task automatic send_keys(input logic [7:0] keys, input logic [7:0] vld, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge Clk);
      InputKey = keys[i];
      ValidCmd = vld[i];
      @(posedge Clk);
    end
  endtask

  task automatic set_div(input logic [31:0] d);
    @(negedge Clk);
    ConfigDiv = 1'b1; Din = d;
    @(negedge Clk);
    ConfigDiv = 1'b0; Din = $urandom;
    exp_period = 2 * ((d == 32'd0) ? 1 : int'(d));
    repeat (20) @(negedge Clk);
  endtask

  task automatic write_op(input logic [7:0] addr, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] sel, input logic [7:0] keys, input int n);
    @(negedge Clk);
    RWMem = 1'b1; Addr = addr; lnA = a; lnB = b; Sel = sel;
    send_keys(keys, 8'hFF, n);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("wr_calc_active", 32'(CalcActive), 32'd1);
    chk("wr_calc_mode",   32'(CalcMode),   32'd1);
    chk("wr_busy_low",    32'(Busy),       32'd0);
    mdl_mem[addr] = ref_word(sel, a, b);
    ValidCmd = 1'b0;
    repeat (3) @(negedge Clk);
    chk("wr_idle_active", 32'(CalcActive), 32'd0);
    chk("wr_idle_mode",   32'(CalcMode),   32'd0);
  endtask

  task automatic read_op(input logic [7:0] addr, input logic [27:0] exp_word, input bit drop);
    int t;
    @(negedge Clk);
    RWMem = 1'b0; Addr = addr;
    exp_q.push_back(exp_word);
    send_keys(8'b1010, 8'hFF, 4);
    t = 0;
    while (!Busy && t < 10) begin @(negedge Clk); t++; end
    chk("rd_busy_rise", 32'(Busy), 32'd1);
    if (drop) ValidCmd = 1'b0;
    t = 0;
    while (Busy && t < 40 * exp_period + 20) begin @(negedge Clk); t++; end
    chk("rd_busy_fall", 32'(Busy), 32'd0);
    chk("rd_dout_valid_low", 32'(DOutValid), 32'd0);
    chk("rd_word_received", 32'(exp_q.size()), 32'd0);
    if (!drop) chk("rd_done_active", 32'(CalcActive), 32'd1);
    exp_q.delete();
    ValidCmd = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rd_idle_active", 32'(CalcActive), 32'd0);
  endtask

  task automatic broken_key(input logic [7:0] keys, input logic [7:0] vld, input int n, input string name);
    bit seen;
    seen = 1'b0;
    RWMem = 1'b1;
    send_keys(keys, vld, n);
    repeat (6) begin
      @(negedge Clk);
      if (CalcActive) seen = 1'b1;
    end
    chk(name, 32'(seen), 32'd0);
    ValidCmd = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a, b, ad;
    logic [3:0] s;
    int t;

    do_reset();

    // Store the reference word and read it back at ClkTx period 4.
    write_op(8'd2, 8'hAB, 8'hCD, 4'd0, 8'b1010, 4);
    set_div(32'd2);
    read_op(8'd2, 28'h0ABCD78, 1'b0);

    // New live operands must not affect a readback; ValidCmd drops during TX.
    @(negedge Clk);
    lnA = 8'h0A; lnB = 8'h0B; Sel = 4'd7;
    read_op(8'd2, 28'h0ABCD78, 1'b1);

    // Broken key sequences never activate.
    broken_key(8'b100, 8'b111, 3, "key_100_no_unlock");
    broken_key(8'b1010, 8'b1101, 4, "vld_drop_no_unlock");
    broken_key(8'b1000, 8'b1111, 4, "key_1000_no_unlock");

    // A stray 1 at K3 restarts at K1: 1,0,1,1,0,1,0 unlocks.
    write_op(8'd5, 8'h3C, 8'h02, 4'd4, 8'b1011010, 7);
    read_op(8'd5, model_read(8'd5), 1'b0);

    // ALU sweep with A=0x0A, B=0x0B; divider 0 behaves as 1.
    for (int k = 0; k < 16; k++) write_op(8'(16 + k), 8'h0A, 8'h0B, 4'(k), 8'b1010, 4);
    set_div(32'd0);
    for (int k = 0; k < 16; k++) begin
      lnA = $urandom; lnB = $urandom; Sel = $urandom;
      case (k)
        0:       read_op(8'd16, 28'h00A0B15, 1'b0);
        1:       read_op(8'd17, 28'h10A0BFF, 1'b0);
        3:       read_op(8'd19, 28'h30A0B00, 1'b0);
        default: read_op(8'(16 + k), model_read(8'(16 + k)), 1'b0);
      endcase
    end

    // Divide by zero.
    a = 8'($urandom_range(1, 255));
    write_op(8'd40, a, 8'h00, 4'd3, 8'b1010, 4);
    read_op(8'd40, {4'd3, a, 8'h00, 8'h00}, 1'b0);

    // Random writes and readbacks at random dividers.
    for (int k = 0; k < 6; k++) begin
      set_div(32'($urandom_range(1, 3)));
      a = $urandom; b = $urandom; s = $urandom; ad = $urandom;
      if (k == 5) b = 8'($urandom_range(0, 9));
      write_op(ad, a, b, s, 8'b1010, 4);
      lnA = $urandom; lnB = $urandom; Sel = $urandom;
      read_op(ad, model_read(ad), 1'b0);
      ad = $urandom;
      read_op(ad, model_read(ad), 1'b0);
    end

    // Reset in the middle of a transmission.
    set_div(32'd1);
    @(negedge Clk);
    RWMem = 1'b0; Addr = 8'd2;
    exp_q.push_back(model_read(8'd2));
    send_keys(8'b1010, 8'hFF, 4);
    t = 0;
    while (mon_nbits < 5 && t < 400) begin @(negedge Clk); t++; end
    chk("rst_tx_in_progress", 32'(mon_nbits >= 5), 32'd1);
    do_reset();
    read_op(8'd2, 28'h0000000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
